// File: rtl/up_ack_aggregator.sv
// Collects acks and read data from several up_* register slaves for up_axi.
// A per-direction watchdog issues a synthetic ack so a silent slave cannot stall the bus.

module up_ack_tracker #(
  parameter int NUM_SLAVES     = 3,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [13:0]           addr,
  input  logic [NUM_SLAVES-1:0] ack_s,
  output logic                  accept,
  output logic                  timeout,
  output logic                  stray,
  output logic                  multi,
  output logic [13:0]           addr_lat
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [13:0] addr_reg, addr_next;
  logic        ack_any;

  assign ack_any  = |ack_s;
  assign addr_lat = addr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (req && !ack_any) begin
          state_next = WAIT;
          cnt_next   = '0;
          addr_next  = addr;
        end
      end
      WAIT: begin
        // A real ack on the final cycle still beats the watchdog.
        if (ack_any || cnt_reg == CNT_LAST) state_next = IDLE;
        else                                cnt_next   = cnt_reg + 16'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    timeout = 1'b0;
    stray   = 1'b0;
    case (state_reg)
      IDLE: begin
        accept = req && ack_any;
        stray  = !req && ack_any;
      end
      WAIT: begin
        accept  = ack_any;
        timeout = !ack_any && (cnt_reg == CNT_LAST);
      end
      default: ;
    endcase
    // More than one bit set: clearing the lowest set bit leaves something behind.
    multi = accept && ((ack_s & (ack_s - NUM_SLAVES'(1))) != '0);
  end

endmodule

module up_ack_aggregator #(
  parameter int          NUM_SLAVES     = 3,
  parameter int          TIMEOUT_CYCLES = 32,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADDEAD,
  parameter int          OUTPUT_REG     = 1
) (
  input  logic                     up_clk,
  input  logic                     up_rst,
  input  logic                     up_wreq,
  input  logic [13:0]              up_waddr,
  input  logic                     up_rreq,
  input  logic [13:0]              up_raddr,
  input  logic [NUM_SLAVES-1:0]    up_wack_s,
  input  logic [NUM_SLAVES-1:0]    up_rack_s,
  input  logic [NUM_SLAVES*32-1:0] up_rdata_s,
  output logic                     up_wack,
  output logic                     up_rack,
  output logic [31:0]              up_rdata,
  input  logic                     up_err_clr,
  output logic                     up_err_timeout,
  output logic                     up_err_multi,
  output logic                     up_err_stray,
  output logic [14:0]              up_err_addr,
  output logic [7:0]               up_timeout_cnt
);

  logic        w_accept, w_timeout, w_stray, w_multi;
  logic        r_accept, r_timeout, r_stray, r_multi;
  logic [13:0] w_addr_lat, r_addr_lat;
  logic        wack_c, rack_c;
  logic [31:0] rdata_c;
  logic [31:0] or_chain [NUM_SLAVES+1];

  up_ack_tracker #(.NUM_SLAVES(NUM_SLAVES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr (
    .clk(up_clk), .rst(up_rst), .req(up_wreq), .addr(up_waddr), .ack_s(up_wack_s),
    .accept(w_accept), .timeout(w_timeout), .stray(w_stray), .multi(w_multi),
    .addr_lat(w_addr_lat)
  );

  up_ack_tracker #(.NUM_SLAVES(NUM_SLAVES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd (
    .clk(up_clk), .rst(up_rst), .req(up_rreq), .addr(up_raddr), .ack_s(up_rack_s),
    .accept(r_accept), .timeout(r_timeout), .stray(r_stray), .multi(r_multi),
    .addr_lat(r_addr_lat)
  );

  assign or_chain[0] = '0;
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_or
    assign or_chain[gi+1] = or_chain[gi] | up_rdata_s[32*gi +: 32];
  end

  assign wack_c  = w_accept | w_timeout;
  assign rack_c  = r_accept | r_timeout;
  assign rdata_c = r_accept  ? or_chain[NUM_SLAVES] :
                   r_timeout ? TIMEOUT_RDATA : 32'h0;

  if (OUTPUT_REG != 0) begin : g_out_reg
    always_ff @(posedge up_clk or posedge up_rst) begin
      if (up_rst) begin
        up_wack  <= 1'b0;
        up_rack  <= 1'b0;
        up_rdata <= '0;
      end else begin
        up_wack  <= wack_c;
        up_rack  <= rack_c;
        up_rdata <= rdata_c;
      end
    end
  end else begin : g_out_comb
    assign up_wack  = wack_c;
    assign up_rack  = rack_c;
    assign up_rdata = rdata_c;
  end

  logic        err_timeout_next, err_multi_next, err_stray_next;
  logic [14:0] err_addr_next;
  logic [7:0]  cnt_base;
  logic [8:0]  cnt_sum;
  logic [7:0]  cnt_next;

  // A clear in the same cycle as an error loses to the error.
  always_comb begin
    cnt_base         = up_err_clr ? 8'd0 : up_timeout_cnt;
    cnt_sum          = {1'b0, cnt_base} + {8'd0, w_timeout} + {8'd0, r_timeout};
    cnt_next         = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    err_timeout_next = (up_err_timeout & ~up_err_clr) | w_timeout | r_timeout;
    err_multi_next   = (up_err_multi   & ~up_err_clr) | w_multi   | r_multi;
    err_stray_next   = (up_err_stray   & ~up_err_clr) | w_stray   | r_stray;
    err_addr_next    = up_err_clr ? 15'd0 : up_err_addr;
    if (r_timeout)      err_addr_next = {1'b1, r_addr_lat};
    else if (w_timeout) err_addr_next = {1'b0, w_addr_lat};
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      up_err_timeout <= 1'b0;
      up_err_multi   <= 1'b0;
      up_err_stray   <= 1'b0;
      up_err_addr    <= '0;
      up_timeout_cnt <= '0;
    end else begin
      up_err_timeout <= err_timeout_next;
      up_err_multi   <= err_multi_next;
      up_err_stray   <= err_stray_next;
      up_err_addr    <= err_addr_next;
      up_timeout_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_up_ack_aggregator.sv
// Directed bench: a vector table on the registered-output instance plus hand
// sequences for timeouts, saturation, clear priority and reset on a combinational instance.

module tb_up_ack_aggregator;

  logic        up_clk = 1'b0;
  logic        up_rst = 1'b1;
  logic        up_wreq = 1'b0, up_rreq = 1'b0, up_err_clr = 1'b0;
  logic [13:0] up_waddr = '0, up_raddr = '0;
  logic [2:0]  up_wack_s = '0, up_rack_s = '0;
  logic [95:0] up_rdata_s = '0;
  logic        up_wack, up_rack, up_err_timeout, up_err_multi, up_err_stray;
  logic [31:0] up_rdata;
  logic [14:0] up_err_addr;
  logic [7:0]  up_timeout_cnt;

  logic        rst2 = 1'b1;
  logic        wreq2 = 1'b0, rreq2 = 1'b0, clr2 = 1'b0;
  logic [13:0] waddr2 = '0, raddr2 = '0;
  logic [2:0]  wack_s2 = '0, rack_s2 = '0;
  logic [95:0] rdata_s2 = '0;
  logic        wack2, rack2, et2, em2, es2;
  logic [31:0] rdata2;
  logic [14:0] eaddr2;
  logic [7:0]  ecnt2;

  int passed = 0;
  int total  = 0;

  always #5 up_clk = ~up_clk;

  up_ack_aggregator #(.NUM_SLAVES(3), .TIMEOUT_CYCLES(32), .TIMEOUT_RDATA(32'hDEADDEAD), .OUTPUT_REG(1)) dut (
    .up_clk(up_clk), .up_rst(up_rst), .up_wreq(up_wreq), .up_waddr(up_waddr),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_wack_s(up_wack_s), .up_rack_s(up_rack_s),
    .up_rdata_s(up_rdata_s), .up_wack(up_wack), .up_rack(up_rack), .up_rdata(up_rdata),
    .up_err_clr(up_err_clr), .up_err_timeout(up_err_timeout), .up_err_multi(up_err_multi),
    .up_err_stray(up_err_stray), .up_err_addr(up_err_addr), .up_timeout_cnt(up_timeout_cnt)
  );

  up_ack_aggregator #(.NUM_SLAVES(3), .TIMEOUT_CYCLES(32), .TIMEOUT_RDATA(32'hDEADDEAD), .OUTPUT_REG(0)) dut_comb (
    .up_clk(up_clk), .up_rst(rst2), .up_wreq(wreq2), .up_waddr(waddr2),
    .up_rreq(rreq2), .up_raddr(raddr2), .up_wack_s(wack_s2), .up_rack_s(rack_s2),
    .up_rdata_s(rdata_s2), .up_wack(wack2), .up_rack(rack2), .up_rdata(rdata2),
    .up_err_clr(clr2), .up_err_timeout(et2), .up_err_multi(em2),
    .up_err_stray(es2), .up_err_addr(eaddr2), .up_timeout_cnt(ecnt2)
  );

  typedef struct {
    logic        wreq;
    logic [13:0] waddr;
    logic [2:0]  wack;
    logic        rreq;
    logic [13:0] raddr;
    logic [2:0]  rack;
    logic [95:0] rdata;
    logic        clr;
    logic        e_wack;
    logic        e_rack;
    logic [31:0] e_rdata;
    logic        e_to;
    logic        e_multi;
    logic        e_stray;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [13:0] wa, input logic [2:0] wk,
                              input logic rr, input logic [13:0] ra, input logic [2:0] rk,
                              input logic [95:0] rd, input logic clr,
                              input logic ew, input logic er, input logic [31:0] ed,
                              input logic et, input logic em, input logic es);
    vec_t v;
    v.wreq = wr; v.waddr = wa; v.wack = wk; v.rreq = rr; v.raddr = ra; v.rack = rk;
    v.rdata = rd; v.clr = clr; v.e_wack = ew; v.e_rack = er; v.e_rdata = ed;
    v.e_to = et; v.e_multi = em; v.e_stray = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs on the registered instance and sample just after the edge.
  task automatic cyc(input logic wr, input logic [13:0] wa, input logic [2:0] wk,
                     input logic rr, input logic [13:0] ra, input logic [2:0] rk,
                     input logic [95:0] rd, input logic clr);
    @(negedge up_clk);
    up_wreq = wr; up_waddr = wa; up_wack_s = wk;
    up_rreq = rr; up_raddr = ra; up_rack_s = rk;
    up_rdata_s = rd; up_err_clr = clr;
    @(posedge up_clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 14'd0, 3'b000, 1'b0, 14'd0, 3'b000, 96'd0, 1'b0);
  endtask

  task automatic clr();
    cyc(1'b0, 14'd0, 3'b000, 1'b0, 14'd0, 3'b000, 96'd0, 1'b1);
  endtask

  task automatic read_timeout(input logic [13:0] ra);
    cyc(1'b0, 14'd0, 3'b000, 1'b1, ra, 3'b000, 96'd0, 1'b0);
    for (int n = 0; n < 32; n++) idle();
  endtask

  initial begin
    int first, pulses;
    logic [31:0] cap_rdata;
    logic        seen;

    //            wr wa      wk      rr ra      rk      rdata                                          clr  ew er edata          to mu st
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b000, 96'd0,                                         0,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 1, 14'h10, 3'b000, 96'd0,                                         0,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b100, {32'h12345678, 64'd0},                          0,  0, 1, 32'h12345678, 0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b000, 96'd0,                                         0,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 1, 14'h11, 3'b001, {64'd0, 32'h000000FF},                          0,  0, 1, 32'h000000FF, 0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b000, 96'd0,                                         0,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 14'h5, 3'b010, 0, 14'h0,  3'b000, 96'd0,                                         0,  1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b000, 96'd0,                                         0,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b001, 0, 14'h0,  3'b000, 96'd0,                                         0,  0, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b000, 96'd0,                                         1,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 14'h6, 3'b011, 0, 14'h0,  3'b000, 96'd0,                                         0,  1, 0, 32'h0,        0, 1, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b000, 96'd0,                                         0,  0, 0, 32'h0,        0, 1, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b000, 96'd0,                                         1,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 1, 14'h12, 3'b101, {32'h0000000F, 32'd0, 32'h0000F000},             0,  0, 1, 32'h0000F00F, 0, 1, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b000, 96'd0,                                         1,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 14'h7, 3'b000, 0, 14'h0,  3'b000, 96'd0,                                         0,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b000, 96'd0,                                         0,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b100, 0, 14'h0,  3'b000, 96'd0,                                         0,  1, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 1, 14'h1,  3'b000, 96'd0,                                         0,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 1, 14'h2,  3'b000, 96'd0,                                         0,  0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b010, {32'd0, 32'h00000055, 32'd0},                   0,  0, 1, 32'h00000055, 0, 0, 0));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b010, {32'd0, 32'h00000055, 32'd0},                   0,  0, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 14'h0, 3'b000, 0, 14'h0,  3'b000, 96'd0,                                         1,  0, 0, 32'h0,        0, 0, 0));

    // Reset state on both instances.
    repeat (2) @(posedge up_clk);
    #1;
    check("reset_outputs", {27'd0, up_wack, up_rack, up_rdata, up_err_timeout, up_err_multi, up_err_stray},
          64'd0);
    check("reset_addr_cnt", {41'd0, up_err_addr, up_timeout_cnt}, 64'd0);
    check("reset_comb", {25'd0, wack2, rack2, rdata2, et2, em2, es2, ecnt2 == 8'd0 ? 1'b0 : 1'b1}, 64'd0);
    @(negedge up_clk);
    up_rst = 1'b0;
    rst2   = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].wreq, vecs[i].waddr, vecs[i].wack, vecs[i].rreq, vecs[i].raddr,
          vecs[i].rack, vecs[i].rdata, vecs[i].clr);
      $display("vec%0d wack=%b rack=%b rdata=%h to=%b multi=%b stray=%b", i, up_wack, up_rack,
               up_rdata, up_err_timeout, up_err_multi, up_err_stray);
      check($sformatf("vec%0d", i),
            {27'd0, up_wack, up_rack, up_rdata, up_err_timeout, up_err_multi, up_err_stray},
            {27'd0, vecs[i].e_wack, vecs[i].e_rack, vecs[i].e_rdata, vecs[i].e_to,
             vecs[i].e_multi, vecs[i].e_stray});
    end

    // Read timeout: synthetic ack visible exactly 32 sampled cycles after the request.
    cyc(1'b0, 14'd0, 3'b000, 1'b1, 14'h0102, 3'b000, 96'd0, 1'b0);
    first = 0; pulses = 0; cap_rdata = '0;
    for (int n = 1; n <= 36; n++) begin
      idle();
      if (up_rack) begin
        pulses++;
        if (first == 0) begin
          first = n;
          cap_rdata = up_rdata;
        end
      end
    end
    $display("read timeout: first rack at %0d, pulses %0d, rdata %h", first, pulses, cap_rdata);
    check("to_latency", 64'(first), 64'd32);
    check("to_pulses", 64'(pulses), 64'd1);
    check("to_rdata", {32'd0, cap_rdata}, {32'd0, 32'hDEADDEAD});
    check("to_flags", {61'd0, up_err_timeout, up_err_multi, up_err_stray}, 64'b100);
    check("to_addr_cnt", {41'd0, up_err_addr, up_timeout_cnt}, {41'd0, 15'h4102, 8'd1});

    // Late slave ack after the timeout is a stray, not forwarded.
    cyc(1'b0, 14'd0, 3'b000, 1'b0, 14'd0, 3'b100, {32'hCAFEF00D, 64'd0}, 1'b0);
    $display("late rack: rack=%b stray=%b", up_rack, up_err_stray);
    check("late_rack_dropped", {62'd0, up_rack, up_err_stray}, 64'b01);
    clr();
    check("clr_all", {38'd0, up_err_timeout, up_err_multi, up_err_stray, up_err_addr, up_timeout_cnt},
          64'd0);

    // Write timeout, then simultaneous write+read timeouts (read wins the address).
    cyc(1'b1, 14'h0033, 3'b000, 1'b0, 14'd0, 3'b000, 96'd0, 1'b0);
    for (int n = 0; n < 32; n++) idle();
    $display("write timeout: wack=%b addr=%h cnt=%0d", up_wack, up_err_addr, up_timeout_cnt);
    check("wto", {40'd0, up_wack, up_err_addr, up_timeout_cnt}, {40'd0, 1'b1, 15'h0033, 8'd1});
    cyc(1'b1, 14'h0044, 3'b000, 1'b1, 14'h1FFF, 3'b000, 96'd0, 1'b0);
    for (int n = 0; n < 31; n++) idle();
    check("dual_to_early", {62'd0, up_wack, up_rack}, 64'd0);
    idle();
    $display("dual timeout: wack=%b rack=%b addr=%h cnt=%0d", up_wack, up_rack, up_err_addr, up_timeout_cnt);
    check("dual_to", {39'd0, up_wack, up_rack, up_err_addr, up_timeout_cnt},
          {39'd0, 1'b1, 1'b1, 15'h5FFF, 8'd3});

    // Saturating timeout counter over 260 back-to-back read timeouts.
    clr();
    for (int k = 1; k <= 260; k++) begin
      read_timeout(14'(k));
      if (k == 254) check("cnt_254", 64'(up_timeout_cnt), 64'd254);
      if (k == 255) check("cnt_255", 64'(up_timeout_cnt), 64'd255);
    end
    $display("after 260 timeouts: cnt=%0d addr=%h", up_timeout_cnt, up_err_addr);
    check("cnt_sat", {41'd0, up_err_addr, up_timeout_cnt}, {41'd0, 15'h4104, 8'd255});

    // Clear coinciding with a timeout: the event wins.
    cyc(1'b0, 14'd0, 3'b000, 1'b1, 14'h0ABC, 3'b000, 96'd0, 1'b0);
    for (int n = 0; n < 31; n++) idle();
    clr();
    $display("clr with timeout: to=%b addr=%h cnt=%0d", up_err_timeout, up_err_addr, up_timeout_cnt);
    check("clr_vs_to", {40'd0, up_err_timeout, up_err_addr, up_timeout_cnt},
          {40'd0, 1'b1, 15'h4ABC, 8'd1});

    // Combinational instance: ack and data in the same cycle as the request.
    @(negedge up_clk);
    rreq2 = 1'b1; raddr2 = 14'h0020; rack_s2 = 3'b001; rdata_s2 = {64'd0, 32'h000000A5};
    #1;
    $display("comb read: rack=%b rdata=%h", rack2, rdata2);
    check("comb_rack", {31'd0, rack2, rdata2}, {31'd0, 1'b1, 32'h000000A5});
    @(negedge up_clk);
    rreq2 = 1'b0; rack_s2 = 3'b000; rdata_s2 = '0;
    #1;
    check("comb_idle", {31'd0, rack2, rdata2}, 64'd0);

    // Reset during WAIT: nothing may emerge after release.
    @(negedge up_clk);
    rreq2 = 1'b1; raddr2 = 14'h0021;
    @(negedge up_clk);
    rreq2 = 1'b0;
    repeat (10) @(negedge up_clk);
    rst2 = 1'b1;
    #1;
    check("rst_mid_outputs", {62'd0, rack2, et2}, 64'd0);
    repeat (2) @(negedge up_clk);
    rst2 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 45; n++) begin
      @(negedge up_clk);
      #1;
      if (rack2 || wack2) seen = 1'b1;
    end
    $display("after reset release: ack seen=%b timeout=%b", seen, et2);
    check("rst_no_ack", {62'd0, seen, et2}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
